// File: rtl/inst_encode.sv
// inst_encode: packs decoded-form RV32I operations into 32-bit instruction
// words and queues them, each tagged with an incrementing instruction-memory
// word address, for the program loader. Illegal beats are dropped and counted.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   flush               synchronous clear of FIFO and address counter
//   in_valid/in_ready   input handshake; in_ready never depends on out_ready
//   in_kind             0 R-ALU, 1 I-ALU, 2 LUI, 3 JAL, 4 JALR, 5 BRANCH,
//                       6 LW, 7 SW, 8 AUIPC
//   in_alu_func         0 add .. 9 sra (same encoding as the decoder)
//   in_br_func          0 beq .. 5 bgeu
//   in_rd/rs1/rs2/imm   operand fields
//   out_valid/out_ready output handshake at FIFO head
//   out_inst, out_addr  encoded word and its word address (zero when empty)
//   err                 one-cycle pulse after an illegal beat was accepted
//   inst_count          legal beats encoded (saturating)
//   err_count           illegal beats dropped (saturating)
module inst_encode #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [3:0]        in_alu_func,
    input  logic [2:0]        in_br_func,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [15:0]       inst_count,
    output logic [7:0]        err_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [3:0] {
        K_RALU   = 4'd0,
        K_IALU   = 4'd1,
        K_LUI    = 4'd2,
        K_JAL    = 4'd3,
        K_JALR   = 4'd4,
        K_BRANCH = 4'd5,
        K_LW     = 4'd6,
        K_SW     = 4'd7,
        K_AUIPC  = 4'd8
    } kind_e;

    kind_e       kind;
    logic [2:0]  alu_f3;
    logic [6:0]  alu_f7;
    logic        alu_ok;
    logic        is_shift;
    logic [2:0]  br_f3;
    logic        br_ok;
    logic        s12_ok;
    logic        s13_ok;
    logic        s21_ok;
    logic [31:0] enc_inst;
    logic        enc_legal;

    assign kind = kind_e'(in_kind);

    // Immediate range checks: all bits above the sign bit must match it.
    assign s12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign s13_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign s21_ok = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        alu_f3   = 3'b000;
        alu_f7   = 7'b0000000;
        alu_ok   = 1'b1;
        is_shift = 1'b0;
        case (in_alu_func)
            4'd0: ;
            4'd1: alu_f7 = 7'b0100000;
            4'd2: alu_f3 = 3'b111;
            4'd3: alu_f3 = 3'b110;
            4'd4: alu_f3 = 3'b100;
            4'd5: alu_f3 = 3'b010;
            4'd6: alu_f3 = 3'b011;
            4'd7: begin alu_f3 = 3'b001; is_shift = 1'b1; end
            4'd8: begin alu_f3 = 3'b101; is_shift = 1'b1; end
            4'd9: begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; is_shift = 1'b1; end
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        br_f3 = 3'b000;
        br_ok = 1'b1;
        case (in_br_func)
            3'd0: br_f3 = 3'b000;
            3'd1: br_f3 = 3'b001;
            3'd2: br_f3 = 3'b100;
            3'd3: br_f3 = 3'b101;
            3'd4: br_f3 = 3'b110;
            3'd5: br_f3 = 3'b111;
            default: br_ok = 1'b0;
        endcase
    end

    always_comb begin
        enc_inst  = '0;
        enc_legal = 1'b0;
        case (kind)
            K_RALU: begin
                enc_inst  = {alu_f7, in_rs2, in_rs1, alu_f3, in_rd, 7'b0110011};
                enc_legal = alu_ok;
            end
            K_IALU: begin
                if (is_shift) begin
                    enc_inst  = {alu_f7, in_imm[4:0], in_rs1, alu_f3, in_rd, 7'b0010011};
                    enc_legal = ~(|in_imm[31:5]);
                end else begin
                    enc_inst  = {in_imm[11:0], in_rs1, alu_f3, in_rd, 7'b0010011};
                    enc_legal = alu_ok && (in_alu_func != 4'd1) && s12_ok;
                end
            end
            K_LUI: begin
                enc_inst  = {in_imm[31:12], in_rd, 7'b0110111};
                enc_legal = ~(|in_imm[11:0]);
            end
            K_AUIPC: begin
                enc_inst  = {in_imm[31:12], in_rd, 7'b0010111};
                enc_legal = ~(|in_imm[11:0]);
            end
            K_JAL: begin
                enc_inst  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, 7'b1101111};
                enc_legal = s21_ok && !in_imm[0];
            end
            K_JALR: begin
                enc_inst  = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
                enc_legal = s12_ok;
            end
            K_BRANCH: begin
                enc_inst  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, br_f3,
                             in_imm[4:1], in_imm[11], 7'b1100011};
                enc_legal = br_ok && s13_ok && !in_imm[0];
            end
            K_LW: begin
                enc_inst  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
                enc_legal = s12_ok;
            end
            K_SW: begin
                enc_inst  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
                enc_legal = s12_ok;
            end
            default: ;
        endcase
    end

    logic [31:0]       inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [15:0]       inst_cnt_q;
    logic [7:0]        err_cnt_q;
    logic              accept;
    logic              push;
    logic              pop;

    assign in_ready  = rst_n && !flush && (count_q != FULL);
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    // Head is masked to zero when empty so stale entries never leak out.
    assign out_inst   = out_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign out_addr   = out_valid ? addr_mem_q[rd_ptr_q] : '0;
    assign err        = err_q;
    assign inst_count = inst_cnt_q;
    assign err_count  = err_cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= enc_inst;
            addr_mem_q[wr_ptr_q] <= addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= ADDR_W'(BASE_ADDR);
            err_q      <= 1'b0;
            inst_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_q <= accept && !enc_legal;
            if (accept && !enc_legal && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + 1'b1;
            if (push && (inst_cnt_q != '1))
                inst_cnt_q <= inst_cnt_q + 1'b1;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                addr_q   <= ADDR_W'(BASE_ADDR);
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    addr_q   <= addr_q + 1'b1;
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/inst_encode.md
# inst_encode

Instruction encoder/writer for the RV32I core: accepts decoded-form operations (kind, ALU/branch function codes, register indices, immediate) over a valid/ready handshake and packs them into 32-bit RV32I instruction words. It is the inverse of the instruction decoder and uses the same ALU and branch function encodings. Encoded words are buffered in a small FIFO, each tagged with an incrementing instruction-memory word address, for the program loader that fills instruction memory. Illegal combinations are dropped and counted.

## Interface
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- ADDR_W, 10, word-address width
- BASE_ADDR, 0, first word address after reset/flush
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous clear of FIFO and address counter
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_kind  in  4  0 R-ALU, 1 I-ALU, 2 LUI, 3 JAL, 4 JALR, 5 BRANCH, 6 LW, 7 SW, 8 AUIPC, others illegal
- in_alu_func  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- in_br_func  in  3  0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate, byte offset for B/J, full value (low 12 bits zero) for U
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops head when out_valid&&out_ready
- out_inst  out  32  encoded instruction at head
- out_addr  out  ADDR_W  word address at head
- err  out  1  one-cycle pulse: accepted beat was illegal
- inst_count  out  16  legal beats encoded, saturating
- err_count  out  8  illegal beats, saturating

## Operation
- Opcodes: R 0110011, I 0010011, LUI 0110111, JAL 1101111, JALR 1100111, BRANCH 1100011, LW 0000011, SW 0100011, AUIPC 0010111.
- ALU funct3/funct7: add 000/0000000, sub 000/0100000, and 111, or 110, xor 100, slt 010, sltu 011, sll 001, srl 101/0000000, sra 101/0100000; unlisted funct7 = 0.
- I-ALU: sub illegal; sll/srl/sra: in_imm[31:5] must be 0, imm field = {funct7, in_imm[4:0]}; others: in_imm signed 12-bit (bits 31:11 equal).
- BRANCH funct3: 0→000, 1→001, 2→100, 3→101, 4→110, 5→111; 6/7 illegal. in_imm signed 13-bit, bit 0 = 0.
- JAL: signed 21-bit, bit 0 = 0. JALR funct3 000, LW/SW funct3 010: signed 12-bit. LUI/AUIPC: in_imm[11:0] must be 0.
- alu_func >9 illegal for R/I kinds; in_alu_func ignored for non-ALU kinds, in_br_func ignored for non-branch kinds; unused register fields encode as 0 (rd=0 for SW/BRANCH, rs1/rs2=0 where absent).
- Legal beat: pushed with current address; address increments, wraps mod 2^ADDR_W; inst_count += 1 (saturate 0xFFFF).
- Illegal beat: no push, address unchanged, err=1 next cycle, err_count += 1 (saturate 0xFF).

## Timing
- Reset (rst_n=0 at edge): FIFO empty, out_valid=0, err=0, counts 0, address=BASE_ADDR; in_ready=0 while rst_n=0.
- in_ready = rst_n && !flush && (count<DEPTH); depends only on registered state, never on out_ready. Full with simultaneous pop: in_ready stays 0 that cycle.
- Latency: beat accepted at edge N appears at head at N+1 when FIFO was empty; err pulses in cycle N+1.
- Simultaneous push and pop: both occur, count unchanged.
- out_inst/out_addr stable while out_valid&&!out_ready. FIFO order preserved.
- flush: at edge, FIFO emptied, address=BASE_ADDR, no accept that cycle; counters retained; err from previous cycle's beat still pulses.
- Reset mid-stream: all state discarded, pending entries lost.

## Test plan
- R add rd=3 rs1=1 rs2=2 -> out_inst 0x002081B3, out_addr 0 one cycle later; sra rd=1 rs1=2 rs2=3 -> 0x403150B3, addr 1.
- I addi rd=1 rs1=0 imm=0xFFFFFFFF -> 0xFFF00093; LUI rd=5 imm=0x12345000 -> 0x123452B7.
- BRANCH beq rs1=1 rs2=2 imm=8 -> 0x00208463; imm=7 -> err pulse, err_count=1, no push, next legal beat gets unchanged address.
- I-kind sub, imm=4096 on addi, kind=15 -> three err pulses, err_count=3, inst_count unchanged.
- out_ready=0, 5 back-to-back legal beats -> 4 accepted (addr 0..3), in_ready=0; release -> drained in order, 5th accepted as addr 4.
- Queue 3 entries, assert flush with in_valid=1 -> out_valid=0 next cycle, input not taken, next legal beat addr BASE_ADDR; rst_n=0 mid-stream -> all outputs zero.
